// File: rtl/sid_pkg.sv
// SID register map, field widths and address helpers shared by the register bank.
package sid_pkg;

   localparam int unsigned SID_VOICE_STRIDE = 7;
   localparam int unsigned SID_NUM_VOICES   = 3;

   localparam int unsigned FREQ_W = 16;
   localparam int unsigned PW_W   = 12;
   localparam int unsigned FC_W   = 11;

   // Offsets within one voice's register block
   localparam logic [4:0] SID_OFS_FREQ_LO = 5'd0;
   localparam logic [4:0] SID_OFS_FREQ_HI = 5'd1;
   localparam logic [4:0] SID_OFS_PW_LO   = 5'd2;
   localparam logic [4:0] SID_OFS_PW_HI   = 5'd3;
   localparam logic [4:0] SID_OFS_CTRL    = 5'd4;
   localparam logic [4:0] SID_OFS_AD      = 5'd5;
   localparam logic [4:0] SID_OFS_SR      = 5'd6;

   // Absolute register addresses
   localparam logic [4:0] SID_V1_FREQ_LO = 5'h00;
   localparam logic [4:0] SID_V1_FREQ_HI = 5'h01;
   localparam logic [4:0] SID_V1_PW_LO   = 5'h02;
   localparam logic [4:0] SID_V1_PW_HI   = 5'h03;
   localparam logic [4:0] SID_V1_CTRL    = 5'h04;
   localparam logic [4:0] SID_V1_AD      = 5'h05;
   localparam logic [4:0] SID_V1_SR      = 5'h06;
   localparam logic [4:0] SID_V2_FREQ_LO = 5'h07;
   localparam logic [4:0] SID_V2_FREQ_HI = 5'h08;
   localparam logic [4:0] SID_V2_PW_LO   = 5'h09;
   localparam logic [4:0] SID_V2_PW_HI   = 5'h0A;
   localparam logic [4:0] SID_V2_CTRL    = 5'h0B;
   localparam logic [4:0] SID_V2_AD      = 5'h0C;
   localparam logic [4:0] SID_V2_SR      = 5'h0D;
   localparam logic [4:0] SID_V3_FREQ_LO = 5'h0E;
   localparam logic [4:0] SID_V3_FREQ_HI = 5'h0F;
   localparam logic [4:0] SID_V3_PW_LO   = 5'h10;
   localparam logic [4:0] SID_V3_PW_HI   = 5'h11;
   localparam logic [4:0] SID_V3_CTRL    = 5'h12;
   localparam logic [4:0] SID_V3_AD      = 5'h13;
   localparam logic [4:0] SID_V3_SR      = 5'h14;
   localparam logic [4:0] SID_FC_LO      = 5'h15;
   localparam logic [4:0] SID_FC_HI      = 5'h16;
   localparam logic [4:0] SID_RES_FILT   = 5'h17;
   localparam logic [4:0] SID_MODE_VOL   = 5'h18;
   localparam logic [4:0] SID_POTX       = 5'h19;
   localparam logic [4:0] SID_POTY       = 5'h1A;
   localparam logic [4:0] SID_OSC3       = 5'h1B;
   localparam logic [4:0] SID_ENV3       = 5'h1C;

   // First register address of voice v (0-based)
   function automatic logic [4:0] voice_base(input int unsigned v);
      return 5'(SID_VOICE_STRIDE * v);
   endfunction

endpackage

// File: rtl/sid_bus_latch_decay.sv
// Data-bus latch: holds the last written byte and clears it after DECAY_TICKS
// clk_en ticks without a write, modelling charge leakage on the real part.
module sid_bus_latch_decay #(
   parameter int unsigned DECAY_TICKS = 8192,
   parameter int unsigned CW          = 14
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] latch_q
);

   localparam logic [CW-1:0] LAST = CW'(DECAY_TICKS - 1);

   logic [CW-1:0] cnt_q;

   // Write reloads latch and restarts the count; ticks age it until the saturating clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q <= '0;
         cnt_q   <= '0;
      end else if (we) begin
         latch_q <= wdata;
         cnt_q   <= '0;
      end else if (tick) begin
         if (cnt_q == LAST) begin
            latch_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sid_reg_bank.sv
// SID write-only register file with read-back of OSC3/ENV3/POTX/POTY snapshots
// and the decaying bus latch for all other addresses.
module sid_reg_bank
   import sid_pkg::*;
#(
   parameter int unsigned AW          = 5,
   parameter int unsigned DECAY_TICKS = 8192,
   parameter int unsigned CW          = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AW-1:0]         bus_addr,
   input  logic [7:0]            bus_wdata,
   input  logic                  bus_we,
   input  logic                  clk_en,
   output logic [7:0]            bus_rdata,
   output logic [3*FREQ_W-1:0]   freq,
   output logic [3*PW_W-1:0]     pw,
   output logic [23:0]           ctrl,
   output logic [23:0]           ad,
   output logic [23:0]           sr,
   output logic [2:0]            ctrl_wr,
   output logic [FC_W-1:0]       fc,
   output logic [7:0]            res_filt,
   output logic [7:0]            mode_vol,
   input  logic [7:0]            osc3_in,
   input  logic [7:0]            env3_in,
   input  logic [7:0]            potx_in,
   input  logic [7:0]            poty_in
);

   logic [4:0] reg_addr;
   logic [7:0] latch_q;
   logic [7:0] osc3_q, env3_q, potx_q, poty_q;

   assign reg_addr = bus_addr[4:0];

   for (genvar v = 0; v < SID_NUM_VOICES; v++) begin : g_voice
      localparam logic [4:0] BASE = voice_base(v);

      logic [FREQ_W-1:0] freq_q;
      logic [PW_W-1:0]   pw_q;
      logic [7:0]        ctrl_q, ad_q, sr_q;
      logic              ctrl_wr_q;

      // Per-voice register writes and the ctrl-written strobe
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            freq_q    <= '0;
            pw_q      <= '0;
            ctrl_q    <= '0;
            ad_q      <= '0;
            sr_q      <= '0;
            ctrl_wr_q <= 1'b0;
         end else begin
            ctrl_wr_q <= bus_we && (reg_addr == BASE + SID_OFS_CTRL);
            if (bus_we) begin
               case (reg_addr)
                  BASE + SID_OFS_FREQ_LO: freq_q[7:0]  <= bus_wdata;
                  BASE + SID_OFS_FREQ_HI: freq_q[15:8] <= bus_wdata;
                  BASE + SID_OFS_PW_LO:   pw_q[7:0]    <= bus_wdata;
                  BASE + SID_OFS_PW_HI:   pw_q[11:8]   <= bus_wdata[3:0];
                  BASE + SID_OFS_CTRL:    ctrl_q       <= bus_wdata;
                  BASE + SID_OFS_AD:      ad_q         <= bus_wdata;
                  BASE + SID_OFS_SR:      sr_q         <= bus_wdata;
                  default: ;
               endcase
            end
         end
      end

      assign freq[v*FREQ_W +: FREQ_W] = freq_q;
      assign pw[v*PW_W +: PW_W]       = pw_q;
      assign ctrl[v*8 +: 8]           = ctrl_q;
      assign ad[v*8 +: 8]             = ad_q;
      assign sr[v*8 +: 8]             = sr_q;
      assign ctrl_wr[v]               = ctrl_wr_q;
   end

   // Filter and volume register writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fc       <= '0;
         res_filt <= '0;
         mode_vol <= '0;
      end else if (bus_we) begin
         case (reg_addr)
            SID_FC_LO:    fc[2:0]  <= bus_wdata[2:0];
            SID_FC_HI:    fc[10:3] <= bus_wdata;
            SID_RES_FILT: res_filt <= bus_wdata;
            SID_MODE_VOL: mode_vol <= bus_wdata;
            default: ;
         endcase
      end
   end

   // Read-only inputs sampled once per SID cycle so reads see a stable value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         osc3_q <= '0;
         env3_q <= '0;
         potx_q <= '0;
         poty_q <= '0;
      end else if (clk_en) begin
         osc3_q <= osc3_in;
         env3_q <= env3_in;
         potx_q <= potx_in;
         poty_q <= poty_in;
      end
   end

   sid_bus_latch_decay #(
      .DECAY_TICKS (DECAY_TICKS),
      .CW          (CW)
   ) u_latch (
      .clk     (clk),
      .rst     (rst),
      .tick    (clk_en),
      .we      (bus_we),
      .wdata   (bus_wdata),
      .latch_q (latch_q)
   );

   // Registered read mux; the latch path bypasses a same-cycle write so the
   // written byte appears with the same one-clock latency as every other read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_rdata <= '0;
      end else begin
         case (reg_addr)
            SID_POTX: bus_rdata <= potx_q;
            SID_POTY: bus_rdata <= poty_q;
            SID_OSC3: bus_rdata <= osc3_q;
            SID_ENV3: bus_rdata <= env3_q;
            default:  bus_rdata <= bus_we ? bus_wdata : latch_q;
         endcase
      end
   end

endmodule
